// File: rtl/fx_mul_pipe.sv
// Multi-lane handshaked Q-format multiplier with selectable rounding and overflow flagging.
// Define FX_MUL_PIPE_SAT_EN to saturate overflowing lanes instead of wrapping them.

module fx_mul_lane #(
  parameter int WIDTH = 32,
  parameter int QFRAC = 16
) (
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic [1:0]         i_mode,
  output logic [WIDTH-1:0]   o_res,
  output logic               o_ovf
);
  // One spare bit so the +1/2 LSB rounding step can never wrap.
  localparam int PW = 2*WIDTH + 1;
  localparam logic [PW-1:0] HALF = PW'(1) << (QFRAC-1);
  localparam logic [PW-1:0] MASK = (PW'(1) << QFRAC) - PW'(1);

  logic signed [PW-1:0] w_ext, w_sum, w_up, w_flr, w_rnd;
  logic        [PW-1:0] w_frac;

  always_comb begin
    w_ext  = {i_prod[2*WIDTH-1], i_prod};
    w_frac = w_ext & MASK;
    w_flr  = w_ext >>> QFRAC;
    w_sum  = w_ext + $signed(HALF);
    w_up   = w_sum >>> QFRAC;
    case (i_mode)
      2'd0: w_rnd = w_flr;
      2'd2: begin
        // Exact tie goes to even; otherwise the top discarded bit means "above half".
        if (w_frac == HALF) w_rnd = w_flr + $signed(PW'(w_flr[0]));
        else                w_rnd = w_flr + $signed(PW'(w_frac[QFRAC-1]));
      end
      default: w_rnd = w_up;
    endcase
    o_ovf = !((&w_rnd[PW-1:WIDTH-1]) || !(|w_rnd[PW-1:WIDTH-1]));
`ifdef FX_MUL_PIPE_SAT_EN
    if (o_ovf) o_res = w_rnd[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else       o_res = w_rnd[WIDTH-1:0];
`else
    o_res = w_rnd[WIDTH-1:0];
`endif
  end
endmodule

module fx_mul_pipe #(
  parameter int WIDTH   = 32,
  parameter int QFRAC   = 16,
  parameter int LANES   = 2,
  parameter int LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  output logic                   ready_out,
  input  logic [LANES*WIDTH-1:0] a,
  input  logic [LANES*WIDTH-1:0] b,
  input  logic [1:0]             round_mode,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [LANES*WIDTH-1:0] result,
  output logic [LANES-1:0]       ovf,
  output logic                   ovf_sticky,
  input  logic                   clr_sticky
);
  generate
    if (LATENCY < 2) begin : g_bad_lat
      $error("fx_mul_pipe: LATENCY must be >= 2");
    end
    if (QFRAC < 1 || QFRAC >= WIDTH) begin : g_bad_q
      $error("fx_mul_pipe: QFRAC must satisfy 1 <= QFRAC < WIDTH");
    end
  endgenerate

  logic [LATENCY:0]                             w_adv;
  logic [LATENCY-1:0]                           r_vld;
  logic [LANES-1:0][2*WIDTH-1:0]                w_prod;
  logic [LANES-1:0][2*WIDTH-1:0]                r_prod;
  logic [1:0]                                   r_mode;
  logic [LANES-1:0][WIDTH-1:0]                  w_res;
  logic [LANES-1:0]                             w_lovf;
  logic [LATENCY-1:1][LANES-1:0][WIDTH-1:0]     r_res;
  logic [LATENCY-1:1][LANES-1:0]                r_ovf;
  logic                                         r_sticky;
  logic                                         w_xfer_out;

  // A stage may move whenever it is empty or its successor moves, so bubbles collapse.
  always_comb begin
    w_adv[LATENCY] = ready_in;
    for (int k = LATENCY-1; k >= 0; k--)
      w_adv[k] = !r_vld[k] || w_adv[k+1];
  end

  genvar i;
  generate
    for (i = 0; i < LANES; i++) begin : g_lane
      logic [WIDTH-1:0] w_a, w_b;
      assign w_a = a[i*WIDTH +: WIDTH];
      assign w_b = b[i*WIDTH +: WIDTH];
      assign w_prod[i] = {{WIDTH{w_a[WIDTH-1]}}, w_a} * {{WIDTH{w_b[WIDTH-1]}}, w_b};

      fx_mul_lane #(.WIDTH(WIDTH), .QFRAC(QFRAC)) u_lane (
        .i_prod (r_prod[i]),
        .i_mode (r_mode),
        .o_res  (w_res[i]),
        .o_ovf  (w_lovf[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_prod <= '0;
      r_mode <= '0;
      r_res  <= '0;
      r_ovf  <= '0;
    end else begin
      if (w_adv[0]) begin
        r_vld[0] <= valid_in;
        if (valid_in) begin
          r_prod <= w_prod;
          r_mode <= round_mode;
        end
      end
      if (w_adv[1]) begin
        r_vld[1] <= r_vld[0];
        r_res[1] <= w_res;
        r_ovf[1] <= w_lovf;
      end
      for (int k = 2; k < LATENCY; k++) begin
        if (w_adv[k]) begin
          r_vld[k] <= r_vld[k-1];
          r_res[k] <= r_res[k-1];
          r_ovf[k] <= r_ovf[k-1];
        end
      end
    end
  end

  assign w_xfer_out = r_vld[LATENCY-1] && ready_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               r_sticky <= 1'b0;
    else if (w_xfer_out && (|ovf))         r_sticky <= 1'b1;
    else if (clr_sticky)                   r_sticky <= 1'b0;
  end

  assign ready_out  = w_adv[0];
  assign valid_out  = r_vld[LATENCY-1];
  assign result     = r_res[LATENCY-1];
  assign ovf        = r_ovf[LATENCY-1];
  assign ovf_sticky = r_sticky;
endmodule

// File: tb/tb_fx_mul_pipe.sv
// Directed bench for fx_mul_pipe at WIDTH=32, QFRAC=16, LANES=2, LATENCY=3.
module tb_fx_mul_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic        ready_out;
  logic [63:0] a = '0, b = '0;
  logic [1:0]  round_mode = 2'd0;
  logic        valid_out;
  logic        ready_in = 1'b1;
  logic [63:0] result;
  logic [1:0]  ovf;
  logic        ovf_sticky;
  logic        clr_sticky = 1'b0;

  int checks = 0;
  int errors = 0;

  fx_mul_pipe #(.WIDTH(32), .QFRAC(16), .LANES(2), .LATENCY(3)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
    .a(a), .b(b), .round_mode(round_mode), .valid_out(valid_out),
    .ready_in(ready_in), .result(result), .ovf(ovf),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Presents one sample, waits for it at the output (bounded) without consuming it.
  task automatic send_and_get(input logic [63:0] ia, input logic [63:0] ib, input logic [1:0] md,
                              output logic [63:0] res, output logic [1:0] ov, output int lat);
    a = ia; b = ib; round_mode = md; valid_in = 1'b1;
    step;
    valid_in = 1'b0;
    lat = 0;
    while (!valid_out && lat < 10) begin
      step;
      lat++;
    end
    res = valid_out ? result : 'x;
    ov  = valid_out ? ovf : 'x;
  endtask

  task automatic test_reset;
    rst = 1'b1; #2;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out got %b exp 0", valid_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready_out got %b exp 1", ready_out); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b exp 0", ovf_sticky); end
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h exp 0", result); end
    step; step;
    rst = 1'b0;
    step;
  endtask

  task automatic test_basic;
    logic [63:0] r; logic [1:0] o; int lat;
    ready_in = 1'b1;
    send_and_get({32'hFFFF0000, 32'h00018000}, {32'h00008000, 32'h00020000}, 2'd1, r, o, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_latency got %0d exp 2", lat); end
    checks++; if (r[31:0] !== 32'h00030000) begin errors++; $display("FAIL basic_lane0 got %h exp 00030000", r[31:0]); end
    checks++; if (r[63:32] !== 32'hFFFF8000) begin errors++; $display("FAIL basic_lane1 got %h exp ffff8000", r[63:32]); end
    checks++; if (o !== 2'b00) begin errors++; $display("FAIL basic_ovf got %b exp 00", o); end
    step;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL basic_drained got %b exp 0", valid_out); end
  endtask

  task automatic test_rounding;
    logic [31:0] av [3];
    logic [31:0] ex [3][3];
    logic [63:0] r; logic [1:0] o; int lat;
    av[0] = 32'h00000001; ex[0][0] = 32'h0;        ex[0][1] = 32'h1; ex[0][2] = 32'h0;
    av[1] = 32'h00000003; ex[1][0] = 32'h1;        ex[1][1] = 32'h2; ex[1][2] = 32'h2;
    av[2] = 32'hFFFFFFFF; ex[2][0] = 32'hFFFFFFFF; ex[2][1] = 32'h0; ex[2][2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      for (int m = 0; m < 3; m++) begin
        send_and_get({32'h0, av[i]}, {32'h0, 32'h00008000}, 2'(m), r, o, lat);
        checks++;
        if (r[31:0] !== ex[i][m]) begin
          errors++; $display("FAIL round a=%h mode=%0d got %h exp %h", av[i], m, r[31:0], ex[i][m]);
        end
        step;
      end
    end
  endtask

  task automatic test_overflow;
    logic [63:0] r; logic [1:0] o; int lat;
    logic [31:0] exp_r;
`ifdef FX_MUL_PIPE_SAT_EN
    exp_r = 32'h7FFFFFFF;
`else
    exp_r = 32'hFFFE0000;
`endif
    send_and_get({32'h0, 32'h7FFF0000}, {32'h0, 32'h00020000}, 2'd1, r, o, lat);
    checks++; if (r[31:0] !== exp_r) begin errors++; $display("FAIL ovf_result got %h exp %h", r[31:0], exp_r); end
    checks++; if (o !== 2'b01) begin errors++; $display("FAIL ovf_flag got %b exp 01", o); end
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_sticky_early got %b exp 0", ovf_sticky); end
    step;
    checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL ovf_sticky_set got %b exp 1", ovf_sticky); end
    clr_sticky = 1'b1;
    step;
    clr_sticky = 1'b0;
    checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL ovf_sticky_clr got %b exp 0", ovf_sticky); end
  endtask

  task automatic test_back_to_back;
    int k_in = 1, n_out = 0, occ = 0, c = 0;
    bit saw_stall = 0, in_x, out_x;
    b = {32'h0, 32'h00010000}; round_mode = 2'd0;
    while (n_out < 10 && c < 60) begin
      valid_in = (k_in <= 10);
      a = {32'h0, 32'(k_in) << 16};
      ready_in = !(c >= 3 && c <= 8);
      #1;
      checks++;
      if (ready_out !== !(occ == 3 && !ready_in)) begin
        errors++; $display("FAIL b2b_ready cycle %0d got %b occ %0d", c, ready_out, occ);
      end
      if (!ready_out) saw_stall = 1;
      if (valid_out) begin
        checks++;
        if (result[31:0] !== (32'(n_out + 1) << 16)) begin
          errors++; $display("FAIL b2b_result idx %0d got %h exp %h", n_out, result[31:0], 32'(n_out + 1) << 16);
        end
      end
      in_x  = valid_in && ready_out;
      out_x = valid_out && ready_in;
      step;
      if (in_x) k_in++;
      if (out_x) n_out++;
      occ = occ + int'(in_x) - int'(out_x);
      c++;
    end
    valid_in = 1'b0; ready_in = 1'b1;
    checks++; if (n_out !== 10) begin errors++; $display("FAIL b2b_count got %0d exp 10", n_out); end
    checks++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL b2b_stall got %b exp 1", saw_stall); end
    step;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL b2b_extra got %b exp 0", valid_out); end
  endtask

  task automatic test_bubble;
    int got = 0;
    b = {32'h0, 32'h00010000}; round_mode = 2'd0;
    ready_in = 1'b0;
    a = {32'h0, 32'h00070000}; valid_in = 1'b1;
    step;
    valid_in = 1'b0;
    for (int t = 0; t < 3; t++) begin
      #1;
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL bubble_hold t%0d got %b exp 1", t, ready_out); end
      step;
    end
    for (int s = 0; s < 2; s++) begin
      a = {32'h0, 32'(8 + s) << 16}; valid_in = 1'b1;
      #1;
      checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL bubble_fill s%0d got %b exp 1", s, ready_out); end
      step;
    end
    #1;
    checks++; if (ready_out !== 1'b0) begin errors++; $display("FAIL bubble_full got %b exp 0", ready_out); end
    valid_in = 1'b0; ready_in = 1'b1;
    for (int t = 0; t < 10 && got < 3; t++) begin
      #1;
      if (valid_out) begin
        checks++;
        if (result[31:0] !== (32'(7 + got) << 16)) begin
          errors++; $display("FAIL bubble_result idx %0d got %h exp %h", got, result[31:0], 32'(7 + got) << 16);
        end
        got++;
      end
      step;
    end
    checks++; if (got !== 3) begin errors++; $display("FAIL bubble_count got %0d exp 3", got); end
  endtask

  task automatic test_reset_mid;
    logic [63:0] r; logic [1:0] o; int lat;
    int seen = 0;
    ready_in = 1'b1; b = {32'h0, 32'h00010000}; round_mode = 2'd0;
    a = {32'h0, 32'h00110000}; valid_in = 1'b1;
    step;
    a = {32'h0, 32'h00120000};
    step;
    valid_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", valid_out); end
    checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", ready_out); end
    step; step;
    rst = 1'b0;
    for (int t = 0; t < 5; t++) begin
      if (valid_out) seen++;
      step;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_ghost got %0d exp 0", seen); end
    send_and_get({32'h0, 32'h00030000}, {32'h0, 32'h00020000}, 2'd1, r, o, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rstmid_latency got %0d exp 2", lat); end
    checks++; if (r[31:0] !== 32'h00060000) begin errors++; $display("FAIL rstmid_result got %h exp 00060000", r[31:0]); end
    step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_rounding;
    test_overflow;
    test_back_to_back;
    test_bubble;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
